// File: rtl/datapath_unit.sv
// Execute-stage datapath: 8-entry register file, ALU and unsigned compare flags.
// Register reads are combinational; write-back commits on the execute-cycle edge.
module datapath_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IMM_WIDTH  = 21,
  parameter int SHIFT_W    = 5,
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      ra,
  input  logic [IDX_W-1:0]      rb,
  input  logic [IDX_W-1:0]      rc,
  input  logic                  reg_write,
  input  logic                  load_e,
  input  logic [3:0]            opcode_e,
  input  logic                  addressing_mode_e,
  input  logic [IMM_WIDTH-1:0]  immediate_e,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [3:0]            cmp_result,
  input  logic [IDX_W-1:0]      dbg_sel,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MOV = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_ORR = 4'b1001;
  localparam logic [3:0] OP_EOR = 4'b1010;
  localparam logic [3:0] OP_MVN = 4'b1011;
  localparam logic [3:0] OP_LSL = 4'b1100;
  localparam logic [3:0] OP_LSR = 4'b1101;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [SHIFT_W-1:0]    shamt;

  assign op1       = regs[ra];
  assign op2       = addressing_mode_e
                     ? {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, immediate_e}
                     : regs[rb];
  assign shamt     = op2[SHIFT_W-1:0];
  assign ram_wdata = op1;
  assign dbg_data  = regs[dbg_sel];

  always_comb begin
    alu_result = '0;
    case (opcode_e)
      OP_ADD:  alu_result = op1 + op2;
      OP_SUB:  alu_result = op1 - op2;
      OP_MOV:  alu_result = op2;
      OP_AND:  alu_result = op1 & op2;
      OP_ORR:  alu_result = op1 | op2;
      OP_EOR:  alu_result = op1 ^ op2;
      OP_MVN:  alu_result = ~op2;
      OP_LSL:  alu_result = op1 << shamt;
      OP_LSR:  alu_result = op1 >> shamt;
      default: alu_result = '0;
    endcase
  end

  // Flags are produced every cycle; the control unit only samples them on CMP.
  assign cmp_result = {(op1 > op2), (op1 < op2), (op1 != op2), (op1 == op2)};

  assign wb_data = load_e ? ram_rdata : alu_result;

  // Write-back stage boundary: reads in this cycle still see the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_write) begin
      regs[rc] <= wb_data;
    end
  end

endmodule

// File: tb/tb_datapath_unit.sv
// Bench for datapath_unit: directed sequence plus randomized traffic against a
// behavioural register-file model.
module tb_datapath_unit;

  localparam logic [3:0] LDR = 4'b0000, STR = 4'b0001, ADD = 4'b0010, SUB = 4'b0011;
  localparam logic [3:0] MOV = 4'b0100, CMP = 4'b0101, AND = 4'b1000, ORR = 4'b1001;
  localparam logic [3:0] EOR = 4'b1010, MVN = 4'b1011, LSL = 4'b1100, LSR = 4'b1101;

  logic        clk = 0;
  logic        reset = 0;
  logic [2:0]  ra = 0, rb = 0, rc = 0, dbg_sel = 0;
  logic        reg_write = 0, load_e = 0, addressing_mode_e = 0;
  logic [3:0]  opcode_e = 0;
  logic [20:0] immediate_e = 0;
  logic [31:0] ram_rdata = 0;
  logic [31:0] ram_wdata, dbg_data;
  logic [3:0]  cmp_result;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [8];

  datapath_unit dut (
    .clk(clk), .reset(reset), .ra(ra), .rb(rb), .rc(rc),
    .reg_write(reg_write), .load_e(load_e), .opcode_e(opcode_e),
    .addressing_mode_e(addressing_mode_e), .immediate_e(immediate_e),
    .ram_rdata(ram_rdata), .ram_wdata(ram_wdata), .cmp_result(cmp_result),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] op2_ref();
    return addressing_mode_e ? {11'b0, immediate_e} : model[rb];
  endfunction

  function automatic logic [31:0] pow2(input int s);
    longint p = 1;
    repeat (s) p = p * 2;
    return p[31:0];
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint prod;
    int s = int'(b % 32);
    case (op)
      ADD: return 32'(longint'(a) + longint'(b));
      SUB: return 32'(longint'(a) - longint'(b) + 64'h1_0000_0000);
      MOV: return b;
      MVN: return 32'hFFFF_FFFF - b;
      AND: return a & b;
      ORR: return a | b;
      EOR: return a ^ b;
      LSL: begin prod = longint'(a) * longint'(pow2(s)); return prod[31:0]; end
      LSR: return (s == 31) ? {31'b0, a[31]} : a / pow2(s);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] cmp_ref(input logic [31:0] a, input logic [31:0] b);
    logic [3:0] f;
    f = 4'b0000;
    if (a == b) f = 4'b0001;
    else if (a < b) f = 4'b0110;
    else f = 4'b1010;
    return f;
  endfunction

  // Advance one clock edge and apply the architectural effect to the model.
  task automatic tick();
    logic        do_rst = reset;
    logic        do_w   = reg_write;
    logic [2:0]  idx    = rc;
    logic [31:0] val    = load_e ? ram_rdata : alu_ref(opcode_e, model[ra], op2_ref());
    @(posedge clk);
    #1;
    if (do_rst) for (int i = 0; i < 8; i++) model[i] = 32'h0;
    else if (do_w) model[idx] = val;
  endtask

  task automatic drive(input logic [3:0] op, input logic am, input logic [20:0] imm,
                       input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                       input logic we, input logic ld, input logic [31:0] rd);
    opcode_e = op; addressing_mode_e = am; immediate_e = imm;
    ra = a; rb = b; rc = c; reg_write = we; load_e = ld; ram_rdata = rd;
  endtask

  task automatic rd(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    dbg_sel = idx;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic exec(input logic [3:0] op, input logic am, input logic [20:0] imm,
                      input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    drive(op, am, imm, a, b, c, 1'b1, 1'b0, 32'h0);
    tick();
    reg_write = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 32'hX;
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rst_wdata", ram_wdata, 32'h0);
    chk("rst_dbg", dbg_data, 32'h0);
    chk("rst_cmp", {28'h0, cmp_result}, 32'h1);

    exec(MOV, 1, 21'd5, 0, 0, 1);
    rd("mov_r1", 1, 32'h5);
    for (int i = 0; i < 8; i++) if (i != 1) rd("mov_other", 3'(i), 32'h0);

    exec(SUB, 0, 0, 0, 1, 2);
    rd("sub_r2", 2, 32'hFFFF_FFFB);
    exec(ADD, 1, 21'd6, 2, 0, 3);
    rd("add_wrap_r3", 3, 32'h1);

    drive(CMP, 1, 21'd5, 1, 0, 0, 0, 0, 0); #1;
    chk("cmp_eq", {28'h0, cmp_result}, 32'h1);
    tick();
    drive(CMP, 1, 21'd7, 1, 0, 0, 0, 0, 0); #1;
    chk("cmp_lt", {28'h0, cmp_result}, 32'h6);
    tick();
    drive(CMP, 1, 21'd3, 1, 0, 0, 0, 1, 32'h1234); #1;
    chk("cmp_gt", {28'h0, cmp_result}, 32'hA);
    tick();
    rd("hold_r1", 1, 32'h5);
    rd("hold_r2", 2, 32'hFFFF_FFFB);
    rd("hold_r0", 0, 32'h0);

    exec(LSL, 1, 21'd33, 1, 0, 4);
    rd("lsl33_r4", 4, 32'hA);
    exec(LSL, 1, 21'd31, 3, 0, 5);
    rd("lsl31_r5", 5, 32'h8000_0000);
    exec(LSR, 1, 21'd31, 5, 0, 5);
    rd("lsr31_r5", 5, 32'h1);
    exec(MVN, 1, 21'd0, 0, 0, 7);
    rd("mvn_r7", 7, 32'hFFFF_FFFF);

    drive(ADD, 1, 21'd1, 1, 0, 6, 1, 1, 32'hDEAD_BEEF);
    tick();
    drive(STR, 0, 0, 6, 0, 0, 0, 0, 0); #1;
    chk("load_store_wdata", ram_wdata, 32'hDEAD_BEEF);

    exec(MOV, 1, 21'd9, 0, 0, 1);
    exec(ADD, 1, 21'd1, 1, 0, 2);
    rd("b2b_r2", 2, 32'd10);

    drive(MOV, 1, 21'd77, 0, 0, 1, 1, 0, 0);
    rd("rdw_old", 1, 32'd9);
    tick();
    reg_write = 0;
    rd("rdw_new", 1, 32'd77);

    drive(MOV, 1, 21'd123, 0, 0, 3, 1, 0, 0);
    reset = 1;
    tick();
    reset = 0; reg_write = 0;
    for (int i = 0; i < 8; i++) rd("rst_we_clear", 3'(i), 32'h0);

    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom), 1'($urandom), 21'($urandom), 3'($urandom), 3'($urandom),
            3'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) immediate_e = 21'($urandom_range(0, 40));
      reset = ($urandom_range(0, 49) == 0);
      dbg_sel = 3'($urandom);
      #1;
      chk("rnd_wdata", ram_wdata, model[ra]);
      chk("rnd_dbg", dbg_data, model[dbg_sel]);
      chk("rnd_cmp", {28'h0, cmp_result}, {28'h0, cmp_ref(model[ra], op2_ref())});
      tick();
    end
    reset = 0; reg_write = 0;
    for (int i = 0; i < 8; i++) rd("final_reg", 3'(i), model[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
